// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 16-bit shift-add multiplier / restoring divider, one bit per cycle.
// Optional macro MULDIV_SIGNED_EN adds two's-complement operation via a FIXUP state.
`default_nettype none

module mul_div_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic                  signed_op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result_lo,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic                  div_by_zero
);

    localparam int W = DATA_WIDTH;

`ifdef MULDIV_SIGNED_EN
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`endif

    state_t                 state, state_next, end_state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [2*W-1:0]         acc;
    logic [W-1:0]           opnd;
    logic                   sgn;
    logic                   last;

    // Multiply step: accumulator high half gains the multiplicand when the current multiplier bit is set.
    logic [W:0]             mul_sum;
    logic [2*W-1:0]         mul_acc;
    logic [W:0]             div_shift;
    logic [W+1:0]           div_diff;
    logic [2*W-1:0]         div_acc;

    assign last      = (cnt == CNT_WIDTH'(W - 1));
    assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    assign mul_acc   = {mul_sum, acc[W-1:1]};
    assign div_shift = {acc[2*W-1:W], acc[W-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b0, opnd};
    assign div_acc   = div_diff[W+1] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                                     : {div_diff[W-1:0],  acc[W-2:0], 1'b1};

`ifdef MULDIV_SIGNED_EN
    logic           op_r, neg_lo, neg_hi;
    logic           sgn_acc;
    logic [W-1:0]   abs_a, abs_b;
    logic [2*W-1:0] neg_prod;
    assign sgn_acc  = signed_op && !(op && (operand_b == '0));
    assign abs_a    = (sgn_acc && operand_a[W-1]) ? -operand_a : operand_a;
    assign abs_b    = (sgn_acc && operand_b[W-1]) ? -operand_b : operand_b;
    assign neg_prod = -acc;
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;
    assign sgn = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        end_state  = S_DONE;
`ifdef MULDIV_SIGNED_EN
        if (sgn) end_state = S_FIXUP;
`endif
        case (state)
            S_IDLE:  if (start) state_next = op ? S_DIV : S_MUL;
            S_MUL:   if (last) state_next = end_state;
            S_DIV: begin
                if (opnd == '0)  state_next = S_DONE;
                else if (last)   state_next = end_state;
            end
`ifdef MULDIV_SIGNED_EN
            S_FIXUP: state_next = S_DONE;
`endif
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn    <= 1'b0;
            op_r   <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cnt         <= '0;
                    div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
                    sgn    <= sgn_acc;
                    op_r   <= op;
                    neg_lo <= operand_a[W-1] ^ operand_b[W-1];
                    neg_hi <= operand_a[W-1];
                    acc    <= {{W{1'b0}}, op ? abs_a : abs_b};
                    opnd   <= op ? abs_b : abs_a;
`else
                    acc    <= {{W{1'b0}}, op ? operand_a : operand_b};
                    opnd   <= op ? operand_b : operand_a;
`endif
                end
                S_MUL: begin
                    acc <= mul_acc;
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (last && !sgn) begin
                        result_hi <= mul_acc[2*W-1:W];
                        result_lo <= mul_acc[W-1:0];
                    end
                end
                S_DIV: begin
                    if (opnd == '0) begin
                        result_lo   <= '1;
                        result_hi   <= acc[W-1:0];
                        div_by_zero <= 1'b1;
                    end else begin
                        acc <= div_acc;
                        cnt <= cnt + CNT_WIDTH'(1);
                        if (last && !sgn) begin
                            result_hi <= div_acc[2*W-1:W];
                            result_lo <= div_acc[W-1:0];
                        end
                    end
                end
`ifdef MULDIV_SIGNED_EN
                // Core ran on magnitudes; restore signs here.
                S_FIXUP: begin
                    if (!op_r) begin
                        result_hi <= neg_lo ? neg_prod[2*W-1:W] : acc[2*W-1:W];
                        result_lo <= neg_lo ? neg_prod[W-1:0]   : acc[W-1:0];
                    end else begin
                        result_hi <= neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];
                        result_lo <= neg_lo ? -acc[W-1:0]   : acc[W-1:0];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table plus handshake/reset sequences.
`default_nettype none

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        signed_op = 1'b0;
    logic [15:0] operand_a = '0;
    logic [15:0] operand_b = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] result_lo, result_hi;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.DATA_WIDTH(16), .CNT_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .signed_op(signed_op),
        .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation; optional junk start pulse in period glitch_k (0 = none).
    task automatic run(input vec_t v, input int glitch_k);
        bit seen;
        seen = 0;
        @(negedge clk);
        op = v.op; signed_op = v.sgn; operand_a = v.a; operand_b = v.b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        operand_a = 16'(($urandom));
        operand_b = 16'(($urandom));
        op = 1'($urandom);
        for (int k = 1; k <= 30 && !seen; k++) begin
            chk("busy", {31'b0, busy}, 32'd1);
            if (done) begin
                seen = 1;
                chk("latency", k, v.lat);
                chk("result_lo", {16'b0, result_lo}, {16'b0, v.lo});
                chk("result_hi", {16'b0, result_hi}, {16'b0, v.hi});
                chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, v.dbz});
            end
            start = (k == glitch_k);
            if (k == glitch_k) begin
                op = 1'b1; operand_a = 16'h5555; operand_b = 16'h0003;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!seen) begin
            errors++;
            $display("FAIL timeout: no done within 30 cycles, expected at %0d", v.lat);
        end
        chk("idle_after_done", {30'b0, busy, done}, 32'd0);
        chk("hold_lo", {16'b0, result_lo}, {16'b0, v.lo});
        chk("hold_hi", {16'b0, result_hi}, {16'b0, v.hi});
    endtask

    initial begin
        vec_t v;
        int done_seen;
        vecs[0]  = '{1'b0, 1'b0, 16'h1234, 16'h0056, 16'h1D78, 16'h0006, 1'b0, 17};
        vecs[1]  = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17};
        vecs[2]  = '{1'b1, 1'b0, 16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 17};
        vecs[3]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 2};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17};
        vecs[5]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17};
        vecs[6]  = '{1'b1, 1'b0, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 17};
        vecs[7]  = '{1'b0, 1'b0, 16'h8000, 16'h0002, 16'h0000, 16'h0001, 1'b0, 17};
`ifdef MULDIV_SIGNED_EN
        vecs[8]  = '{1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 18};
        vecs[9]  = '{1'b0, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 1'b0, 18};
        vecs[10] = '{1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 18};
`else
        vecs[8]  = '{1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0, 17};
        vecs[9]  = '{1'b0, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 16'h0004, 1'b0, 17};
        vecs[10] = '{1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 17};
`endif
        vecs[11] = '{1'b1, 1'b1, 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1'b1, 2};

        #12;
        chk("reset_outputs", {busy, done, div_by_zero, result_lo, result_hi}, 35'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run(vecs[i], 0);

        // Start pulsed mid-operation must be ignored.
        run(vecs[0], 5);
        // Start during the DONE cycle must be ignored too.
        run(vecs[2], 17);

        // Reset at N+8 aborts without a done pulse.
        @(negedge clk);
        op = 1'b0; signed_op = 1'b0; operand_a = 16'h00FF; operand_b = 16'h00FF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {busy, done, div_by_zero, result_lo, result_hi}, 35'd0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("no_done_after_reset", done_seen, 0);

        v = '{1'b1, 1'b0, 16'hBEEF, 16'h0010, 16'h0BEE, 16'h000F, 1'b0, 17};
        run(v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
